islam_ihfaz_moore: RTL and testbench

//  Moore-type serial sequence detector for pattern "1011", wrapped in the TinyTapeout user-project pinout.

---
 rtl/islam_ihfaz_moore_if.sv | 28 ++
 rtl/islam_ihfaz_moore.sv | 68 ++++++
 tb/tb_islam_ihfaz_moore.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/islam_ihfaz_moore_if.sv
// TinyTapeout user-project pin bundle.
// The harness drives the inputs; the tile drives the outputs.
interface islam_ihfaz_moore_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/islam_ihfaz_moore.sv
// Moore "1011" serial detector with a 4-bit match counter.
// Every output bit comes straight from a register.
module islam_ihfaz_moore (
  input  logic                clk,
  input  logic                rst_n,
  islam_ihfaz_moore_if.slave  io
);

  typedef enum logic [2:0] {
    S0  = 3'b000,
    S1  = 3'b001,
    S2  = 3'b010,
    S3  = 3'b011,
    DET = 3'b100
  } state_t;

  state_t     state;
  logic       det;
  logic [3:0] count;

  logic din;
  logic vld;
  logic clr;
  logic mode;
  logic adv;

  assign din  = io.ui_in[0];
  assign vld  = io.ui_in[1];
  assign clr  = io.ui_in[2];
  assign mode = io.ui_in[3];
  assign adv  = io.ena & vld;

  // rst_n keeps its harness name but is active-high here
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= S0;
      det   <= 1'b0;
      count <= 4'd0;
    end else if (state > DET) begin
      state <= S0;
      det   <= 1'b0;
    end else if (io.ena) begin
      if (clr)
        count <= 4'd0;
      else if (adv && din && state == S3)
        count <= count + 4'd1;
      if (adv) begin
        det <= (state == S3) && din;
        case (state)
          S0:  state <= din ? S1  : S0;
          S1:  state <= din ? S1  : S2;
          S2:  state <= din ? S3  : S0;
          S3:  state <= din ? DET : S2;
          DET: state <= din ? S1  : (mode ? S0 : S2);
          default: state <= S0;
        endcase
      end
    end
  end

  assign io.uo_out  = {count, state, det};
  assign io.uio_out = 8'h00;
  assign io.uio_oe  = 8'h00;

  logic unused_ok;
  assign unused_ok = &{1'b0, io.ui_in[7:4], io.uio_in};

endmodule

// File: tb/tb_islam_ihfaz_moore.sv
// Self-checking bench for islam_ihfaz_moore.
// Reference model tracks the recent bit history, not FSM states.
module tb_islam_ihfaz_moore;

  logic clk;
  logic rst_n;

  islam_ihfaz_moore_if bus ();

  islam_ihfaz_moore dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  logic [3:0] m_hist;
  int         m_len;
  logic       m_det;
  logic [3:0] m_cnt;

  function automatic logic [2:0] m_code();
    if (m_det) return 3'd4;
    if (m_len >= 3 && m_hist[2:0] == 3'b101) return 3'd3;
    if (m_len >= 2 && m_hist[1:0] == 2'b10) return 3'd2;
    if (m_len >= 1 && m_hist[0]) return 3'd1;
    return 3'd0;
  endfunction

  function automatic logic [7:0] m_uo();
    return {m_cnt, m_code(), m_det};
  endfunction

  // one clock: drive after negedge, model at posedge, return at negedge
  task automatic step(input logic rst, input logic en,
                      input logic v, input logic d,
                      input logic c, input logic md);
    logic nd;
    rst_n = rst;
    bus.ena = en;
    bus.ui_in = {$urandom_range(15, 0), md, c, v, d};
    bus.uio_in = 8'($urandom);
    @(posedge clk);
    if (rst) begin
      m_hist = 4'd0;
      m_len = 0;
      m_det = 1'b0;
      m_cnt = 4'd0;
    end else if (en) begin
      nd = m_det;
      if (v) begin
        if (m_det && md) begin
          m_hist = 4'd0;
          m_len = 0;
        end
        m_hist = {m_hist[2:0], d};
        if (m_len < 4) m_len++;
        nd = (m_len == 4) && (m_hist == 4'b1011);
      end
      if (c) m_cnt = 4'd0;
      else if (v && nd) m_cnt = m_cnt + 4'd1;
      m_det = nd;
    end
    @(negedge clk);
  endtask

  task automatic bit_in(input logic d, input logic md);
    step(1'b0, 1'b1, 1'b1, d, 1'b0, md);
  endtask

  task automatic do_reset();
    step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    n_chk++;
    if (bus.uo_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_uo got %h want 00", bus.uo_out);
    end
    n_chk++;
    if (bus.uio_out !== 8'h00 || bus.uio_oe !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_uio got %h/%h want 00/00", bus.uio_out, bus.uio_oe);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] s;
    s = 7'b1011011;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      bit_in(s[i], 1'b0);
      n_chk++;
      if (bus.uo_out !== m_uo()) begin
        n_fail++;
        $display("FAIL overlap_bit%0d got %h want %h", 7 - i, bus.uo_out, m_uo());
      end
      if (i == 2) begin
        n_chk++;
        if (bus.uo_out[3:1] !== 3'b010) begin
          n_fail++;
          $display("FAIL overlap_state5 got %b want 010", bus.uo_out[3:1]);
        end
      end
    end
    n_chk++;
    if (bus.uo_out[7:4] !== 4'd2 || bus.uo_out[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL overlap_end got %h want cnt2 det1", bus.uo_out);
    end
  endtask

  task automatic test_nonoverlap();
    logic [6:0] s;
    s = 7'b1011011;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      bit_in(s[i], 1'b1);
      n_chk++;
      if (bus.uo_out !== m_uo()) begin
        n_fail++;
        $display("FAIL nonov_bit%0d got %h want %h", 7 - i, bus.uo_out, m_uo());
      end
      if (i == 2) begin
        n_chk++;
        if (bus.uo_out[3:1] !== 3'b000) begin
          n_fail++;
          $display("FAIL nonov_state5 got %b want 000", bus.uo_out[3:1]);
        end
      end
    end
    n_chk++;
    if (bus.uo_out[7:4] !== 4'd1 || bus.uo_out[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL nonov_end got %h want cnt1 det0", bus.uo_out);
    end
  endtask

  task automatic test_hold();
    do_reset();
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 1'b0, 1'($urandom), 1'b0, 1'($urandom));
    n_chk++;
    if (bus.uo_out !== 8'h19) begin
      n_fail++;
      $display("FAIL hold_valid0 got %h want 19", bus.uo_out);
    end
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
    n_chk++;
    if (bus.uo_out !== 8'h19 || bus.uo_out !== m_uo()) begin
      n_fail++;
      $display("FAIL hold_ena0 got %h want 19", bus.uo_out);
    end
  endtask

  task automatic test_counter();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      bit_in(1'b1, 1'b0);
      bit_in(1'b0, 1'b0);
      bit_in(1'b1, 1'b0);
      bit_in(1'b1, 1'b0);
      if (k == 14) begin
        n_chk++;
        if (bus.uo_out[7:4] !== 4'd15) begin
          n_fail++;
          $display("FAIL cnt_15 got %0d want 15", bus.uo_out[7:4]);
        end
      end
    end
    n_chk++;
    if (bus.uo_out !== 8'h09 || bus.uo_out !== m_uo()) begin
      n_fail++;
      $display("FAIL cnt_wrap got %h want 09", bus.uo_out);
    end
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    n_chk++;
    if (bus.uo_out[7:4] !== 4'd1) begin
      n_fail++;
      $display("FAIL cnt_one got %0d want 1", bus.uo_out[7:4]);
    end
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_chk++;
    if (bus.uo_out !== 8'h09 || bus.uo_out !== m_uo()) begin
      n_fail++;
      $display("FAIL cnt_clr got %h want 09", bus.uo_out);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    n_chk++;
    if (bus.uo_out[3:1] !== 3'b011) begin
      n_fail++;
      $display("FAIL mid_pre got %b want 011", bus.uo_out[3:1]);
    end
    do_reset();
    n_chk++;
    if (bus.uo_out !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_rst got %h want 00", bus.uo_out);
    end
    bit_in(1'b1, 1'b0);
    n_chk++;
    if (bus.uo_out !== 8'h02) begin
      n_fail++;
      $display("FAIL mid_after got %h want 02", bus.uo_out);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(99, 0) == 0),
           ($urandom_range(9, 0) != 0),
           ($urandom_range(3, 0) != 0),
           1'($urandom),
           ($urandom_range(19, 0) == 0),
           1'($urandom));
      n_chk++;
      if (bus.uo_out !== m_uo()) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL random_c%0d got %h want %h", i, bus.uo_out, m_uo());
        errs++;
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    m_hist = 4'd0;
    m_len = 0;
    m_det = 1'b0;
    m_cnt = 4'd0;
    rst_n = 1'b1;
    bus.ena = 1'b0;
    bus.ui_in = 8'h00;
    bus.uio_in = 8'h00;
    @(negedge clk);
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_hold();
    test_counter();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
